scan_mux: RTL

Parametrised N-channel, W-bit selector with a registered output and an auto-scan mode that steps through channels on a programmable dwell count. It generalises the fixed 8-to-1 selector used in the drill set to arbitrary channel count and data width. It sits between a bank of source registers and a single downstream consumer, such as a display driver or serial shifter, that needs either a fixed channel or a time-multiplexed sweep.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/dwell_counter.sv | 29 ++
 rtl/scan_mux.sv | 93 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and width helpers for the scan_mux channel selector.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (longint unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    // Index width: at least one bit, even when the count is 1 or 2.
    function automatic int sel_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Modulo-DWELL cycle counter; tick flags the last cycle of each dwell period.
module dwell_counter
    import mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = sel_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/scan_mux.sv
// N-channel, W-bit registered selector with manual selection and a dwell-timed auto-scan.
module scan_mux
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SW   = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] din,
    input  logic           en,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   dout,
    output logic [SW-1:0]  ch,
    output logic           valid,
    output logic           wrap
);

    localparam logic [SW-1:0] LAST = SW'(N - 1);

    state_t        state, state_next, target;
    logic [W-1:0]  chans [N];
    logic [SW-1:0] csel;
    logic          clr, cnt_en, tick, step;

    // Out-of-range indices only exist when N is not a power of two.
    if (N == (1 << SW)) begin : g_pow2
        assign csel = sel;
    end else begin : g_clamp
        assign csel = (sel > LAST) ? LAST : sel;
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            chans[k] = din[k*W +: W];
        end
    end

    // Any state entry (including leaving IDLE) restarts the dwell from zero.
    always_comb begin
        target     = mode ? SCAN : MANUAL;
        state_next = en ? target : state;
        clr        = en && (state != target);
        cnt_en     = en && (target == SCAN);
        step       = en && (state == SCAN) && (target == SCAN) && tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (cnt_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                valid <= 1'b1;
                if (target == MANUAL) begin
                    ch   <= csel;
                    dout <= chans[csel];
                end else begin
                    dout <= chans[ch];
                    if (step) begin
                        ch <= (ch == LAST) ? '0 : ch + 1'b1;
                    end
                    wrap <= step && (ch == LAST);
                end
            end
        end
    end

endmodule
